// File: rtl/sram_data_bridge.sv
// CPU memory-stage to synchronous data SRAM bridge: request/ready handshake, fixed read
// latency return pipe with outstanding-read limit, kseg0/kseg1 translation, optional read alignment.
module sram_data_bridge #(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned RD_LAT          = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          XLAT_EN         = 1'b1,
  parameter bit          ALIGN_EN        = 1'b0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [DATA_W/8-1:0]   cpu_sel,
  input  logic                  cpu_sext,
  input  logic [31:0]           cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic                  cpu_ready,
  output logic                  cpu_rvalid,
  output logic [DATA_W-1:0]     cpu_rdata,
  input  logic                  sram_avail,
  output logic                  sram_en,
  output logic [DATA_W/8-1:0]   sram_wen,
  output logic [31:0]           sram_addr,
  output logic [DATA_W-1:0]     sram_wdata,
  input  logic [DATA_W-1:0]     sram_rdata,
  output logic                  busy
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  logic [RD_LAT-1:0] pipe_vld;
  logic [NB-1:0]     pipe_sel  [RD_LAT];
  logic              pipe_sext [RD_LAT];
  logic [CW-1:0]     out_cnt;
  logic [CW-1:0]     cnt_net;
  logic              ret;
  logic              acc;
  logic              rd_acc;
  logic [NB-1:0]     rsel;
  logic              rsext;

  logic [DATA_W-1:0] masked;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] aligned;
  logic              sign;
  int                lo;
  int                pc;
  int                wbits;

  function automatic logic [DATA_W-1:0] lane_mask(input logic [NB-1:0] sel);
    lane_mask = '0;
    for (int i = 0; i < int'(NB); i++) lane_mask[8*i +: 8] = {8{sel[i]}};
  endfunction

  // A read returning this cycle frees its slot for a read accepted in the same cycle
  assign ret       = pipe_vld[RD_LAT-1];
  assign cnt_net   = out_cnt - CW'(ret);
  assign cpu_ready = sram_avail & (cpu_we | (cnt_net < CW'(MAX_OUTSTANDING)));
  assign acc       = cpu_req & cpu_ready;
  assign rd_acc    = acc & ~cpu_we;

  assign sram_en    = acc & (|cpu_sel);
  assign sram_wen   = {NB{acc & cpu_we}} & cpu_sel;
  assign sram_wdata = cpu_wdata & lane_mask(cpu_sel);
  assign sram_addr  = (XLAT_EN && (cpu_addr[31:29] == 3'b100 || cpu_addr[31:29] == 3'b101))
                      ? {3'b000, cpu_addr[28:0]} : cpu_addr;

  assign cpu_rvalid = ret;
  assign busy       = (out_cnt != '0);
  assign rsel       = pipe_sel[RD_LAT-1];
  assign rsext      = pipe_sext[RD_LAT-1];

  // Return pipe and outstanding-read counter; the pipe shifts every cycle and never stalls
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pipe_vld <= '0;
      for (int k = 0; k < int'(RD_LAT); k++) begin
        pipe_sel[k]  <= '0;
        pipe_sext[k] <= 1'b0;
      end
      out_cnt <= '0;
    end else begin
      pipe_vld[0]  <= rd_acc;
      pipe_sel[0]  <= cpu_sel;
      pipe_sext[0] <= cpu_sext;
      for (int k = 1; k < int'(RD_LAT); k++) begin
        pipe_vld[k]  <= pipe_vld[k-1];
        pipe_sel[k]  <= pipe_sel[k-1];
        pipe_sext[k] <= pipe_sext[k-1];
      end
      out_cnt <= out_cnt + CW'(rd_acc) - CW'(ret);
    end
  end

  // Read data lane masking, optional shift-down and sign/zero extension
  always_comb begin
    masked = sram_rdata & lane_mask(rsel);
    lo     = 0;
    pc     = 0;
    for (int i = int'(NB) - 1; i >= 0; i--) begin
      if (rsel[i]) begin
        lo = i;
        pc = pc + 1;
      end
    end
    shifted = masked >> (8 * lo);
    wbits   = 8 * pc;
    sign    = 1'b0;
    for (int b = 0; b < int'(DATA_W); b++) begin
      if (b == wbits - 1) sign = shifted[b];
    end
    aligned = shifted;
    for (int b = 0; b < int'(DATA_W); b++) begin
      if (b >= wbits) aligned[b] = rsext & sign;
    end
    cpu_rdata = '0;
    if (ret) cpu_rdata = ALIGN_EN ? aligned : masked;
  end

endmodule
